pipelined_ripple_adder: RTL

PIPELINED_RIPPLE_ADDER -- requirements
Module: pipelined_ripple_adder

---
 rtl/ripple_carry_chunk.sv | 36 +++
 rtl/pipelined_ripple_adder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ripple_carry_chunk.sv
// ============================================================================
// Module   : ripple_carry_chunk
// Purpose  : Combinational CHUNK-bit ripple-carry adder built from full-adder
//            cells; also exposes the carry into its most significant bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_carry_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout    = carry[CHUNK];
  assign msb_cin = carry[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_ripple_adder.sv
// ============================================================================
// Module   : pipelined_ripple_adder
// Purpose  : WIDTH-bit add/subtract unit, one CHUNK-bit ripple slice per
//            pipeline stage, valid/ready handshake with global stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;

  generate
    if ((CHUNK < 1) || (WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("pipelined_ripple_adder: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             advance;

  // Stage k holds: sum chunks 0..k finished, operands still carried for
  // the upper chunks (skew), and the carry out of chunk k.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic             ovf_q;
  logic             ovf_d;

  logic [CHUNK-1:0] ch_sum  [STAGES];
  logic             ch_cout [STAGES];
  logic             ch_msbc [STAGES];

  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~cin : cin;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK-1:0] op_a;
      logic [CHUNK-1:0] op_b;
      logic             op_c;

      if (k == 0) begin : g_first
        assign op_a = a[CHUNK-1:0];
        assign op_b = b_eff[CHUNK-1:0];
        assign op_c = c_eff;
      end else begin : g_next
        assign op_a = a_q[k-1][k*CHUNK +: CHUNK];
        assign op_b = b_q[k-1][k*CHUNK +: CHUNK];
        assign op_c = c_q[k-1];
      end

      ripple_carry_chunk #(
        .CHUNK   (CHUNK)
      ) u_chunk (
        .a       (op_a),
        .b       (op_b),
        .cin     (op_c),
        .sum     (ch_sum[k]),
        .cout    (ch_cout[k]),
        .msb_cin (ch_msbc[k])
      );
    end
  endgenerate

  always_comb begin
    advance = !valid_q[STAGES-1] || out_ready;

    a_d[0]     = a;
    b_d[0]     = b_eff;
    s_d[0]     = '0;
    s_d[0][CHUNK-1:0] = ch_sum[0];
    c_d[0]     = ch_cout[0];
    valid_d[0] = in_valid;

    for (int k = 1; k < STAGES; k++) begin
      a_d[k]     = a_q[k-1];
      b_d[k]     = b_q[k-1];
      s_d[k]     = s_q[k-1];
      s_d[k][k*CHUNK +: CHUNK] = ch_sum[k];
      c_d[k]     = ch_cout[k];
      valid_d[k] = valid_q[k-1];
    end

    ovf_d = ch_msbc[STAGES-1] ^ ch_cout[STAGES-1];
  end

  // Reset wins over advance; a stalled pipeline holds every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign in_ready  = advance && !rst;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

`default_nettype wire
